cv32e40p_scnn_lif: RTL and testbench

Leaky integrate-and-fire (LIF) neuron stage that sits directly downstream of the SCNN spike-multiply accumulator. On `start_i` it adds one 8×16 tile of signed 16-bit partial sums into 128 persistent membrane potentials, then applies leak, threshold and reset. It emits one 16-bit spike row per handshake, eight rows per run. It tells the accumulator to clear its cache once the tile has been captured.

---
 rtl/cv32e40p_scnn_pkg.sv | 21 ++
 rtl/cv32e40p_scnn_lif_neuron.sv | 58 +++++
 rtl/cv32e40p_scnn_lif.sv | 154 +++++++++++++++
 tb/tb_cv32e40p_scnn_lif.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cv32e40p_scnn_pkg.sv
// Shared constants and types for the SCNN accumulator / LIF neuron stage.
package cv32e40p_scnn_pkg;

    localparam int unsigned SCNN_ROWS  = 8;
    localparam int unsigned SCNN_COLS  = 16;
    localparam int unsigned SCNN_DW    = 16;
    localparam int unsigned SCNN_ROW_W = 3;

    typedef enum logic [1:0] {
        LIF_IDLE = 2'd0,
        LIF_CALC = 2'd1,
        LIF_SEND = 2'd2,
        LIF_DONE = 2'd3
    } scnn_lif_state_e;

    typedef enum logic {
        RST_ZERO = 1'b0,
        RST_SUB  = 1'b1
    } scnn_lif_rst_mode_e;

endpackage

// File: rtl/cv32e40p_scnn_lif_neuron.sv
// One LIF neuron update: leak, integrate with saturation, fire, reset.
module cv32e40p_scnn_lif_neuron
    import cv32e40p_scnn_pkg::*;
#(
    parameter int unsigned DW = SCNN_DW
) (
    input  logic [DW-1:0]      v_i,
    input  logic [DW-1:0]      psum_i,
    input  logic [DW-1:0]      thr_i,
    input  logic [3:0]         leak_shift_i,
    input  scnn_lif_rst_mode_e mode_i,
    output logic [DW-1:0]      v_nxt_c,
    output logic               spike_c
);

    // Two guard bits so every intermediate sum/difference is exact before clamping.
    localparam int unsigned            EW   = DW + 2;
    localparam logic signed [EW-1:0]   VMAX = EW'((1 << (DW - 1)) - 1);
    localparam logic signed [EW-1:0]   VMIN = ~VMAX;

    function automatic logic [DW-1:0] sat(input logic signed [EW-1:0] x);
        logic [DW-1:0] r;
        if (x > VMAX) begin
            r = VMAX[DW-1:0];
        end else if (x < VMIN) begin
            r = VMIN[DW-1:0];
        end else begin
            r = x[DW-1:0];
        end
        return r;
    endfunction

    logic signed [EW-1:0] v_ext;
    logic signed [EW-1:0] p_ext;
    logic signed [EW-1:0] t_ext;
    logic signed [EW-1:0] leak_v;
    logic signed [EW-1:0] u_ext;
    logic [DW-1:0]        u;

    // Leak with arithmetic shift, integrate, compare against threshold, then reset.
    always_comb begin
        v_ext  = EW'($signed(v_i));
        p_ext  = EW'($signed(psum_i));
        t_ext  = EW'($signed(thr_i));
        leak_v = v_ext;
        if (leak_shift_i != 4'd0) begin
            leak_v = v_ext - (v_ext >>> leak_shift_i);
        end
        u       = sat(leak_v + p_ext);
        u_ext   = EW'($signed(u));
        spike_c = (u_ext >= t_ext);
        v_nxt_c = u;
        if (spike_c) begin
            v_nxt_c = (mode_i == RST_ZERO) ? '0 : sat(u_ext - t_ext);
        end
    end

endmodule

// File: rtl/cv32e40p_scnn_lif.sv
// LIF neuron stage: folds one partial-sum tile into 128 membranes, one row per CALC cycle,
// and streams the resulting spike rows out with a valid/ready handshake.
module cv32e40p_scnn_lif
    import cv32e40p_scnn_pkg::*;
#(
    parameter int unsigned ROWS = SCNN_ROWS,
    parameter int unsigned COLS = SCNN_COLS,
    parameter int unsigned DW   = SCNN_DW
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start_i,
    input  logic [ROWS-1:0][COLS-1:0][DW-1:0] cache_i,
    input  logic [DW-1:0]                     threshold_i,
    input  logic [3:0]                        leak_shift_i,
    input  logic                              reset_mode_i,
    input  logic                              clear_mem_i,
    output logic                              cache_clr_o,
    output logic                              busy_o,
    output logic                              done_o,
    output logic                              spike_valid_o,
    input  logic                              spike_ready_i,
    output logic [SCNN_ROW_W-1:0]             spike_row_o,
    output logic [COLS-1:0]                   spike_data_o
);

    localparam int unsigned RW = SCNN_ROW_W;

    scnn_lif_state_e                 state_q, state_d;
    logic [RW-1:0]                   row_q, row_d;
    logic [ROWS-1:0][COLS-1:0][DW-1:0] mem_q, mem_d;
    logic [ROWS-1:0][COLS-1:0][DW-1:0] snap_q, snap_d;
    logic [DW-1:0]                   thr_q, thr_d;
    logic [3:0]                      leak_q, leak_d;
    scnn_lif_rst_mode_e              mode_q, mode_d;
    logic                            busy_q, busy_d;
    logic                            done_q, done_d;
    logic                            cache_clr_q, cache_clr_d;
    logic                            spike_valid_q, spike_valid_d;
    logic [COLS-1:0]                 spike_data_q, spike_data_d;

    logic [COLS-1:0][DW-1:0]         row_v_nxt;
    logic [COLS-1:0]                 row_spike;

    // One neuron datapath per column, all operating on the currently selected row.
    for (genvar c = 0; c < int'(COLS); c++) begin : g_neuron
        cv32e40p_scnn_lif_neuron #(
            .DW (DW)
        ) u_neuron (
            .v_i          (mem_q[row_q][c]),
            .psum_i       (snap_q[row_q][c]),
            .thr_i        (thr_q),
            .leak_shift_i (leak_q),
            .mode_i       (mode_q),
            .v_nxt_c      (row_v_nxt[c]),
            .spike_c      (row_spike[c])
        );
    end

    // Next-state, datapath updates and registered-output values.
    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        mem_d        = mem_q;
        snap_d       = snap_q;
        thr_d        = thr_q;
        leak_d       = leak_q;
        mode_d       = mode_q;
        cache_clr_d  = 1'b0;
        spike_data_d = spike_data_q;

        unique case (state_q)
            LIF_IDLE: begin
                // Clear lands in mem_d before CALC ever reads it, so clear+start runs from zero.
                if (clear_mem_i) begin
                    mem_d = '0;
                end
                if (start_i) begin
                    snap_d      = cache_i;
                    thr_d       = threshold_i;
                    leak_d      = leak_shift_i;
                    mode_d      = scnn_lif_rst_mode_e'(reset_mode_i);
                    row_d       = '0;
                    cache_clr_d = 1'b1;
                    state_d     = LIF_CALC;
                end
            end
            LIF_CALC: begin
                mem_d[row_q] = row_v_nxt;
                spike_data_d = row_spike;
                state_d      = LIF_SEND;
            end
            LIF_SEND: begin
                if (spike_ready_i) begin
                    if (row_q == RW'(ROWS - 1)) begin
                        state_d = LIF_DONE;
                    end else begin
                        row_d   = row_q + RW'(1);
                        state_d = LIF_CALC;
                    end
                end
            end
            LIF_DONE: begin
                state_d = LIF_IDLE;
            end
            default: begin
                state_d = LIF_IDLE;
            end
        endcase

        busy_d        = (state_d != LIF_IDLE);
        done_d        = (state_d == LIF_DONE);
        spike_valid_d = (state_d == LIF_SEND);
    end

    // State, membrane, snapshot and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= LIF_IDLE;
            row_q         <= '0;
            mem_q         <= '0;
            snap_q        <= '0;
            thr_q         <= '0;
            leak_q        <= '0;
            mode_q        <= RST_ZERO;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            cache_clr_q   <= 1'b0;
            spike_valid_q <= 1'b0;
            spike_data_q  <= '0;
        end else begin
            state_q       <= state_d;
            row_q         <= row_d;
            mem_q         <= mem_d;
            snap_q        <= snap_d;
            thr_q         <= thr_d;
            leak_q        <= leak_d;
            mode_q        <= mode_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            cache_clr_q   <= cache_clr_d;
            spike_valid_q <= spike_valid_d;
            spike_data_q  <= spike_data_d;
        end
    end

    assign cache_clr_o   = cache_clr_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign spike_valid_o = spike_valid_q;
    assign spike_row_o   = row_q;
    assign spike_data_o  = spike_data_q;

endmodule

// File: tb/tb_cv32e40p_scnn_lif.sv
// Self-checking bench for cv32e40p_scnn_lif: directed table, stall/reset sequences, random runs.
`timescale 1ns/1ps
module tb_cv32e40p_scnn_lif;
    import cv32e40p_scnn_pkg::*;

    logic clk;
    logic rst_n;
    logic start_i;
    logic [SCNN_ROWS-1:0][SCNN_COLS-1:0][SCNN_DW-1:0] cache_i;
    logic [SCNN_DW-1:0] threshold_i;
    logic [3:0]  leak_shift_i;
    logic        reset_mode_i;
    logic        clear_mem_i;
    logic        cache_clr_o;
    logic        busy_o;
    logic        done_o;
    logic        spike_valid_o;
    logic        spike_ready_i;
    logic [2:0]  spike_row_o;
    logic [SCNN_COLS-1:0] spike_data_o;

    cv32e40p_scnn_lif dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_i       (start_i),
        .cache_i       (cache_i),
        .threshold_i   (threshold_i),
        .leak_shift_i  (leak_shift_i),
        .reset_mode_i  (reset_mode_i),
        .clear_mem_i   (clear_mem_i),
        .cache_clr_o   (cache_clr_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .spike_valid_o (spike_valid_o),
        .spike_ready_i (spike_ready_i),
        .spike_row_o   (spike_row_o),
        .spike_data_o  (spike_data_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int run_id   = 0;

    // Reference membranes, plain integers.
    int mem_m [8][16];

    typedef struct {
        bit          clr;
        int          cache;
        int          thr;
        int          k;
        bit          mode;
        logic [15:0] exp_word;
    } vec_t;

    vec_t tbl [21];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    function automatic int sat16(input int x);
        if (x > 32767) return 32767;
        if (x < -32768) return -32768;
        return x;
    endfunction

    function automatic int floor_div(input int a, input int d);
        if (a >= 0) return a / d;
        return -((-a + d - 1) / d);
    endfunction

    task automatic model_clear();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 16; c++)
                mem_m[r][c] = 0;
    endtask

    task automatic fill_uniform(input int v);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 16; c++)
                cache_i[r][c] = 16'(v);
    endtask

    task automatic fill_random();
        int v;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 16; c++) begin
                case ($urandom_range(0, 7))
                    0:       v = -32768;
                    1:       v = 32767;
                    default: v = int'($urandom_range(0, 800)) - 400;
                endcase
                cache_i[r][c] = 16'(v);
            end
    endtask

    // Starts a run at the current negedge (cycle 0) and follows it to the first IDLE cycle.
    // rmode: 0 ready always high, 1 random ready, 2 three-cycle stall on row 2 plus stray start/clear.
    task automatic do_run(input bit clr, input int thr, input int k, input bit mode,
                          input int rmode, input bit has_exp, input logic [15:0] texp);
        logic [15:0] expw [8];
        logic [15:0] want;
        int  v, l, u, p;
        bit  s;
        int  cyc, nrows, stalls, done_cyc, first_v, clr_cnt, clr_cyc, busy_bad, st2, hold_bad;
        bit  fin, rdy;

        run_id++;
        if (clr) model_clear();
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 16; c++) begin
                p = int'($signed(cache_i[r][c]));
                v = mem_m[r][c];
                l = (k == 0) ? v : v - floor_div(v, 1 << k);
                u = sat16(l + p);
                s = (u >= thr);
                expw[r][c] = s;
                mem_m[r][c] = s ? (mode ? sat16(u - thr) : 0) : u;
            end
        end

        start_i       = 1'b1;
        clear_mem_i   = clr;
        threshold_i   = 16'(thr);
        leak_shift_i  = 4'(k);
        reset_mode_i  = mode;
        spike_ready_i = 1'b1;

        cyc = 0; nrows = 0; stalls = 0; done_cyc = -1; first_v = -1;
        clr_cnt = 0; clr_cyc = -1; busy_bad = 0; st2 = 0; hold_bad = 0; fin = 1'b0;
        while (!fin && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                start_i     = 1'b0;
                clear_mem_i = 1'b0;
                fill_random();
            end
            if (rmode == 2 && cyc == 5) begin
                start_i     = 1'b1;
                clear_mem_i = 1'b1;
            end
            if (rmode == 2 && cyc == 6) begin
                start_i     = 1'b0;
                clear_mem_i = 1'b0;
            end
            if (done_cyc >= 0) begin
                chk($sformatf("run%0d idle_busy", run_id), 32'(busy_o), 32'd0);
                chk($sformatf("run%0d idle_done", run_id), 32'(done_o), 32'd0);
                fin = 1'b1;
            end else begin
                if (cache_clr_o) begin
                    clr_cnt++;
                    clr_cyc = cyc;
                end
                if (busy_o !== 1'b1) busy_bad++;
                if (spike_valid_o && first_v < 0) first_v = cyc;
                if (done_o) done_cyc = cyc;
                case (rmode)
                    1:       rdy = ($urandom_range(0, 9) < 7);
                    2:       rdy = !(spike_valid_o && spike_row_o == 3'd2 && st2 < 3);
                    default: rdy = 1'b1;
                endcase
                if (rmode == 2 && !rdy) st2++;
                spike_ready_i = rdy;
                if (spike_valid_o) begin
                    if (!rdy) begin
                        stalls++;
                        if (spike_row_o !== 3'd2 || spike_data_o !== expw[2]) hold_bad++;
                    end else if (nrows < 8) begin
                        want = has_exp ? texp : expw[nrows];
                        chk($sformatf("run%0d row%0d index", run_id, nrows),
                            32'(spike_row_o), 32'(nrows));
                        chk($sformatf("run%0d row%0d data", run_id, nrows),
                            32'(spike_data_o), 32'(want));
                        nrows++;
                    end else begin
                        nrows++;
                    end
                end
            end
        end
        spike_ready_i = 1'b1;

        chk($sformatf("run%0d completed_in_budget", run_id), 32'(fin), 32'd1);
        chk($sformatf("run%0d rows_emitted", run_id), 32'(nrows), 32'd8);
        chk($sformatf("run%0d done_cycle", run_id), 32'(done_cyc), 32'(17 + stalls));
        chk($sformatf("run%0d first_valid_cycle", run_id), 32'(first_v), 32'd2);
        chk($sformatf("run%0d cache_clr_count", run_id), 32'(clr_cnt), 32'd1);
        chk($sformatf("run%0d cache_clr_cycle", run_id), 32'(clr_cyc), 32'd1);
        chk($sformatf("run%0d busy_low_during_run", run_id), 32'(busy_bad), 32'd0);
        if (rmode == 2) begin
            chk("stall_cycles", 32'(stalls), 32'd3);
            chk("stall_done_cycle", 32'(done_cyc), 32'd20);
            chk("stall_hold_stable", 32'(hold_bad), 32'd0);
        end
    endtask

    initial begin
        bit found;
        int thr, k;

        tbl[0]  = '{1'b1,     60,    100, 0, 1'b0, 16'h0000};
        tbl[1]  = '{1'b0,     60,    100, 0, 1'b0, 16'hFFFF};
        tbl[2]  = '{1'b0,      0,    100, 0, 1'b0, 16'h0000};
        tbl[3]  = '{1'b1,    150,    100, 0, 1'b1, 16'hFFFF};
        tbl[4]  = '{1'b0,      0,    100, 0, 1'b1, 16'h0000};
        tbl[5]  = '{1'b0,     50,    100, 0, 1'b1, 16'hFFFF};
        tbl[6]  = '{1'b1,     64,    100, 1, 1'b0, 16'h0000};
        tbl[7]  = '{1'b0,      0,    100, 1, 1'b0, 16'h0000};
        tbl[8]  = '{1'b0,     68,    100, 1, 1'b0, 16'h0000};
        tbl[9]  = '{1'b0,     16,    100, 0, 1'b0, 16'hFFFF};
        tbl[10] = '{1'b1,     -3,    100, 1, 1'b0, 16'h0000};
        tbl[11] = '{1'b0,      0,    100, 1, 1'b0, 16'h0000};
        tbl[12] = '{1'b0,      0,      0, 0, 1'b0, 16'h0000};
        tbl[13] = '{1'b0,      0,     -1, 0, 1'b0, 16'hFFFF};
        tbl[14] = '{1'b1, -32768,    100, 0, 1'b0, 16'h0000};
        tbl[15] = '{1'b0, -32768,    100, 0, 1'b0, 16'h0000};
        tbl[16] = '{1'b0,  32767,    100, 0, 1'b0, 16'h0000};
        tbl[17] = '{1'b0,      0,      0, 0, 1'b0, 16'h0000};
        tbl[18] = '{1'b0,      0,     -1, 0, 1'b0, 16'hFFFF};
        tbl[19] = '{1'b1,  32767, -32768, 0, 1'b1, 16'hFFFF};
        tbl[20] = '{1'b0,      0,  32767, 0, 1'b0, 16'hFFFF};

        rst_n         = 1'b0;
        start_i       = 1'b0;
        clear_mem_i   = 1'b0;
        threshold_i   = '0;
        leak_shift_i  = '0;
        reset_mode_i  = 1'b0;
        spike_ready_i = 1'b0;
        fill_uniform(0);
        model_clear();

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset busy_o", 32'(busy_o), 32'd0);
        chk("reset done_o", 32'(done_o), 32'd0);
        chk("reset cache_clr_o", 32'(cache_clr_o), 32'd0);
        chk("reset spike_valid_o", 32'(spike_valid_o), 32'd0);
        chk("reset spike_row_o", 32'(spike_row_o), 32'd0);
        chk("reset spike_data_o", 32'(spike_data_o), 32'd0);

        // Directed table, back-to-back runs with ready held high.
        for (int i = 0; i < 21; i++) begin
            fill_uniform(tbl[i].cache);
            do_run(tbl[i].clr, tbl[i].thr, tbl[i].k, tbl[i].mode, 0, 1'b1, tbl[i].exp_word);
        end

        // Backpressure on row 2 with a stray start/clear mid-run.
        fill_random();
        do_run(1'b1, 60, 1, 1'b1, 2, 1'b0, 16'h0000);
        fill_random();
        do_run(1'b0, 120, 0, 1'b0, 0, 1'b0, 16'h0000);

        // Reset while row 4 is pending.
        fill_uniform(-500);
        start_i       = 1'b1;
        clear_mem_i   = 1'b1;
        threshold_i   = 16'd100;
        leak_shift_i  = 4'd0;
        reset_mode_i  = 1'b0;
        spike_ready_i = 1'b1;
        found = 1'b0;
        for (int i = 1; i <= 60 && !found; i++) begin
            @(negedge clk);
            if (i == 1) begin
                start_i     = 1'b0;
                clear_mem_i = 1'b0;
            end
            if (spike_valid_o && spike_row_o == 3'd4) found = 1'b1;
        end
        chk("rst reached row4", 32'(found), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst spike_valid_o", 32'(spike_valid_o), 32'd0);
        chk("rst busy_o", 32'(busy_o), 32'd0);
        chk("rst done_o", 32'(done_o), 32'd0);
        chk("rst spike_row_o", 32'(spike_row_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        @(negedge clk);
        fill_uniform(0);
        do_run(1'b0, -1, 0, 1'b0, 0, 1'b1, 16'hFFFF);

        // Clear together with start: negative membranes must read as zero.
        fill_uniform(-500);
        do_run(1'b0, 100, 0, 1'b0, 0, 1'b1, 16'h0000);
        fill_uniform(0);
        do_run(1'b1, -1, 0, 1'b0, 0, 1'b1, 16'hFFFF);

        // Randomized runs against the reference model.
        for (int i = 0; i < 30; i++) begin
            fill_random();
            thr = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 65535)) - 32768
                                              : int'($urandom_range(0, 500)) - 50;
            k   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15))
                                              : int'($urandom_range(0, 2));
            do_run((i == 0) || ($urandom_range(0, 7) == 0), thr, k,
                   bit'($urandom_range(0, 1)), 1, 1'b0, 16'h0000);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
